jtcontra_mixer_n: RTL and testbench
===================================

Name: jtcontra_mixer_n

Overview:
- N-layer colour mixer with CPU-accessible palette RAM.
- Parametrised successor to the two-layer Contra colour mix path.
- Takes per-layer colour indices from LAYERS tile/sprite engines and resolves priority and transparency.
- Looks up a 15-bit BGR palette and drives 5-bit RGB plus blanking delayed to match the pipeline. Sits between the gfx engines and the video output inside the video top.

Parameters:
- LAYERS, 2, number of input pixel layers (1..8).
- PXLW, 7, colour index bits per layer.
- LYRW, derived localparam = max(1, clog2(LAYERS)), layer-id bits in palette address.
- PALW, derived localparam = LYRW+PXLW+1, palette byte-address width.

Ports:
- clk  in  1  system clock (48 MHz).
- rst  in  1  synchronous active-high reset.
- pxl_cen  in  1  pixel clock enable; all video pipeline stages advance only on it.
- cpu_cen  in  1  CPU bus clock enable.
- pal_cs  in  1  palette chip select.
- cpu_rnw  in  1  1=read, 0=write.
- cpu_addr  in  PALW  palette byte address.
- cpu_dout  in  8  CPU write data.
- pal_dout  out  8  palette read data to CPU.
- LHBL  in  1  horizontal blank, active low.
- LVBL  in  1  vertical blank, active low.
- LHBL_dly  out  1  LHBL delayed to align with RGB.
- LVBL_dly  out  1  LVBL delayed to align with RGB.
- layer_pxl  in  LAYERS*PXLW  packed indices; layer k at [k*PXLW +: PXLW].
- gfx_en  in  LAYERS  per-layer enable; 0 forces the layer transparent.
- prio_rev  in  1  0: layer 0 highest priority; 1: layer LAYERS-1 highest.
- red, green, blue  out  5 each  colour output.

Behaviour:
- Reset (synchronous, active-high): red/green/blue=0, LHBL_dly=LVBL_dly=0, pal_dout=0, all pipeline registers cleared. Palette RAM contents are not cleared. The first valid output comes 3 pxl_cen ticks after reset release.
- Palette RAM: 2^PALW bytes, split into even and odd byte banks of 2^(PALW-1) entries each.
- Entry word = {odd, even}. red=w[4:0], green=w[9:5], blue=w[14:10]; w[15] is ignored.
- CPU write: on a clk edge with pal_cs & ~cpu_rnw & cpu_cen, write cpu_dout to byte cpu_addr (bit0 selects the bank).
- CPU read: pal_dout is registered every clk from the byte at cpu_addr, so it is valid 1 clk after the address. Reads are not gated by cpu_cen.
- Transparency: a layer is transparent when its index bits [3:0]==0 or its gfx_en bit is 0.
- Stage 1 (pxl_cen), priority select: scan layers in priority order and pick the first opaque layer L.
  - Register entry address = {L[LYRW-1:0], pxl_L}.
  - If no layer is opaque, entry address = 0 (backdrop).
  - prio_rev is sampled at this stage.
- Stage 2 (pxl_cen): registered read of both banks at the entry address via the video port.
- Stage 3 (pxl_cen): register RGB from the word. Force RGB to 0 when the stage-2-aligned delayed LHBL or LVBL is low.
- Latency: exactly 3 pxl_cen ticks from layer_pxl to RGB.
- LHBL/LVBL pass through a 3-tap shift register clocked on pxl_cen. LHBL_dly and LVBL_dly are its outputs, aligned with the RGB they qualify.
- Collision: a CPU write and a video read of the same byte in the same clk return the old data to the video port (read-before-write). CPU access never stalls video.
- Between pxl_cen pulses all video outputs hold their values.
- LAYERS=1: LYRW=1 and the layer-id bit is always 0.
- Infer the RAM as true dual-port block RAM: one port CPU read/write, one port video read-only.

Test Plan:
- Fill palette, read back: write bytes 0x00..0xFF to addresses 0..255, then read every address -> pal_dout equals the written byte exactly 1 clk after the address, both banks.
- Priority and transparency: with LAYERS=2, set entry 0x012=0x001F and entry 0x094=0x7C00. Drive layer0=0x12, layer1=0x14, prio_rev=0 -> red=31, green=0, blue=0 after 3 pxl_cen. Set prio_rev=1 -> blue=31, red=0.
- Transparency fall-through: layer0=0x10 (index low nibble 0), layer1=0x14 -> layer 1 colour shown. gfx_en=2'b00 -> backdrop (entry 0).
- Blanking: drive LHBL=0 for 4 pixels with opaque input -> RGB=0 and LHBL_dly low for exactly those 4 pixels, delayed by 3 pxl_cen ticks.
- Collision: CPU writes entry 0x012 in the same clk stage 2 reads it -> that pixel shows old colour, the next pixel shows new colour.
- Reset mid-frame: assert rst for 2 clk while RGB is non-zero -> RGB=0, *_dly=0 next clk; palette data preserved on later read-back.

Source files
------------

// File: rtl/jtcontra_mixer_n.sv
// jtcontra_mixer_n: N-layer colour mixer with CPU-accessible 15-bit BGR palette RAM
//
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   pxl_cen               pixel clock enable; every video stage advances on it
//   cpu_cen               CPU bus clock enable (gates writes only)
//   pal_cs, cpu_rnw       palette select, 1=read / 0=write
//   cpu_addr, cpu_dout    palette byte address and write data
//   pal_dout              registered palette read data (1 clk after address)
//   LHBL, LVBL            active-low blanking inputs
//   LHBL_dly, LVBL_dly    blanking delayed to line up with red/green/blue
//   layer_pxl             packed per-layer colour indices, layer k at [k*PXLW +: PXLW]
//   gfx_en                per-layer enable, 0 makes the layer transparent
//   prio_rev              0: layer 0 on top, 1: layer LAYERS-1 on top
//   red, green, blue      5-bit colour output, 3 pxl_cen ticks after layer_pxl
module jtcontra_mixer_n #(
    parameter int LAYERS = 2,
    parameter int PXLW = 7,
    localparam int LYRW = (LAYERS > 1) ? $clog2(LAYERS) : 1,
    localparam int PALW = LYRW + PXLW + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pxl_cen,
    input  logic                     cpu_cen,
    input  logic                     pal_cs,
    input  logic                     cpu_rnw,
    input  logic [PALW-1:0]          cpu_addr,
    input  logic [7:0]               cpu_dout,
    output logic [7:0]               pal_dout,
    input  logic                     LHBL,
    input  logic                     LVBL,
    output logic                     LHBL_dly,
    output logic                     LVBL_dly,
    input  logic [LAYERS*PXLW-1:0]   layer_pxl,
    input  logic [LAYERS-1:0]        gfx_en,
    input  logic                     prio_rev,
    output logic [4:0]               red,
    output logic [4:0]               green,
    output logic [4:0]               blue
);
    localparam int AW = PALW - 1;

    logic [7:0]    even_ram [0:(1<<AW)-1];
    logic [7:0]    odd_ram  [0:(1<<AW)-1];
    logic [AW-1:0] cpu_entry;
    logic          cpu_we;
    logic [7:0]    even_cpu, odd_cpu, even_vid, odd_vid;
    logic          cpu_odd;
    logic [AW-1:0] lo_addr [0:LAYERS];
    logic [AW-1:0] hi_addr [0:LAYERS];
    logic [AW-1:0] sel_addr, entry;
    logic [2:0]    hbl, vbl;
    logic [15:0]   word;
    logic          unused_msb;

    assign cpu_entry = cpu_addr[PALW-1:1];
    assign cpu_we    = pal_cs & ~cpu_rnw & cpu_cen;

    // CPU port: read-before-write, output register cleared by reset
    always_ff @(posedge clk) begin
        if (cpu_we && !cpu_addr[0]) even_ram[cpu_entry] <= cpu_dout;
        even_cpu <= rst ? 8'd0 : even_ram[cpu_entry];
    end

    always_ff @(posedge clk) begin
        if (cpu_we && cpu_addr[0]) odd_ram[cpu_entry] <= cpu_dout;
        odd_cpu <= rst ? 8'd0 : odd_ram[cpu_entry];
    end

    always_ff @(posedge clk) cpu_odd <= rst ? 1'b0 : cpu_addr[0];

    assign pal_dout = cpu_odd ? odd_cpu : even_cpu;

    // Video port: read-only, advances with the pixel pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            even_vid <= 8'd0;
            odd_vid  <= 8'd0;
        end else if (pxl_cen) begin
            even_vid <= even_ram[entry];
            odd_vid  <= odd_ram[entry];
        end
    end

    // Two priority chains: lo_addr[0] holds the lowest opaque layer,
    // hi_addr[LAYERS] the highest; both fall back to the backdrop entry 0.
    assign lo_addr[LAYERS] = '0;
    assign hi_addr[0]      = '0;

    for (genvar g = 0; g < LAYERS; g++) begin : g_layer
        localparam logic [LYRW-1:0] ID = LYRW'(g);
        logic [PXLW-1:0] pix;
        logic            opaque;
        assign pix          = layer_pxl[g*PXLW +: PXLW];
        assign opaque       = gfx_en[g] && (pix[3:0] != 4'd0);
        assign lo_addr[g]   = opaque ? {ID, pix} : lo_addr[g+1];
        assign hi_addr[g+1] = opaque ? {ID, pix} : hi_addr[g];
    end

    assign sel_addr = prio_rev ? hi_addr[LAYERS] : lo_addr[0];

    assign word       = {odd_vid, even_vid};
    assign unused_msb = word[15];

    // hbl/vbl[1] lines up with the palette word, [2] with the RGB registers
    always_ff @(posedge clk) begin
        if (rst) begin
            entry <= '0;
            hbl   <= 3'd0;
            vbl   <= 3'd0;
            red   <= 5'd0;
            green <= 5'd0;
            blue  <= 5'd0;
        end else if (pxl_cen) begin
            entry <= sel_addr;
            hbl   <= {hbl[1:0], LHBL};
            vbl   <= {vbl[1:0], LVBL};
            {blue, green, red} <= (hbl[1] & vbl[1]) ? word[14:0] : 15'd0;
        end
    end

    assign LHBL_dly = hbl[2];
    assign LVBL_dly = vbl[2];
endmodule

// File: tb/tb_jtcontra_mixer_n.sv
// tb_jtcontra_mixer_n: table-driven and randomized check of jtcontra_mixer_n against a behavioural model
module tb_jtcontra_mixer_n;
    localparam int LAYERS = 2;
    localparam int PXLW   = 7;
    localparam int PALW   = 9;

    logic                   clk = 1'b0;
    logic                   rst, pxl_cen, cpu_cen, pal_cs, cpu_rnw;
    logic [PALW-1:0]        cpu_addr;
    logic [7:0]             cpu_dout, pal_dout;
    logic                   LHBL, LVBL, LHBL_dly, LVBL_dly;
    logic [LAYERS*PXLW-1:0] layer_pxl;
    logic [LAYERS-1:0]      gfx_en;
    logic                   prio_rev;
    logic [4:0]             red, green, blue;

    jtcontra_mixer_n #(.LAYERS(LAYERS), .PXLW(PXLW)) dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .cpu_cen(cpu_cen),
        .pal_cs(pal_cs), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr),
        .cpu_dout(cpu_dout), .pal_dout(pal_dout), .LHBL(LHBL), .LVBL(LVBL),
        .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly), .layer_pxl(layer_pxl),
        .gfx_en(gfx_en), .prio_rev(prio_rev), .red(red), .green(green), .blue(blue)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] r, g, b;
        logic       hb, vb;
    } out_t;

    typedef struct {
        logic [6:0] l0, l1;
        logic [1:0] en;
        logic       rev;
        logic [4:0] r, g, b;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] pal [512];
    out_t       q [$];
    out_t       last;
    vec_t       vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input out_t e);
        chk({name, " red"}, red, e.r);
        chk({name, " green"}, green, e.g);
        chk({name, " blue"}, blue, e.b);
        chk({name, " LHBL_dly"}, LHBL_dly, e.hb);
        chk({name, " LVBL_dly"}, LVBL_dly, e.vb);
    endtask

    // Expected pixel: first opaque layer in priority order, else backdrop entry 0
    function automatic out_t model(input logic [LAYERS*PXLW-1:0] px, input logic [LAYERS-1:0] en,
                                   input logic rev, input logic hb, input logic vb);
        int         a, k;
        logic       hit;
        logic [6:0] p;
        logic [15:0] w;
        out_t       o;
        a = 0;
        hit = 1'b0;
        for (int i = 0; i < LAYERS; i++) begin
            k = rev ? LAYERS - 1 - i : i;
            p = px[k*PXLW +: PXLW];
            if (!hit && en[k] && p[3:0] != 4'd0) begin
                hit = 1'b1;
                a = k * (1 << PXLW) + int'(p);
            end
        end
        w = {pal[2*a+1], pal[2*a]};
        o.r  = (hb && vb) ? w[4:0]   : 5'd0;
        o.g  = (hb && vb) ? w[9:5]   : 5'd0;
        o.b  = (hb && vb) ? w[14:10] : 5'd0;
        o.hb = hb;
        o.vb = vb;
        return o;
    endfunction

    task automatic restart_model();
        q = {};
        q.push_back('0);
        q.push_back('0);
        last = '0;
    endtask

    task automatic px_tick(input string name);
        pxl_cen = 1'b1;
        q.push_back(model(layer_pxl, gfx_en, prio_rev, LHBL, LVBL));
        @(posedge clk); #1;
        pxl_cen = 1'b0;
        last = q.pop_front();
        chk_out(name, last);
    endtask

    task automatic idle_tick(input string name);
        pxl_cen = 1'b0;
        @(posedge clk); #1;
        chk_out(name, last);
    endtask

    task automatic cpu_wr(input int a, input logic [7:0] d);
        pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_cen = 1'b1;
        cpu_addr = PALW'(a); cpu_dout = d;
        @(posedge clk); #1;
        pal_cs = 1'b0; cpu_rnw = 1'b1; cpu_cen = 1'b0;
        pal[a] = d;
    endtask

    task automatic cpu_rd(input string name, input int a);
        pal_cs = 1'b1; cpu_rnw = 1'b1; cpu_cen = 1'b0;
        cpu_addr = PALW'(a);
        @(posedge clk); #1;
        chk(name, pal_dout, pal[a]);
    endtask

    task automatic drive(input logic [6:0] l0, input logic [6:0] l1, input logic [1:0] en, input logic rev);
        layer_pxl = {l1, l0};
        gfx_en = en;
        prio_rev = rev;
    endtask

    initial begin
        vecs[0] = '{7'h12, 7'h14, 2'b11, 1'b0, 5'd31, 5'd0,  5'd0};
        vecs[1] = '{7'h12, 7'h14, 2'b11, 1'b1, 5'd0,  5'd0,  5'd31};
        vecs[2] = '{7'h10, 7'h14, 2'b11, 1'b0, 5'd0,  5'd0,  5'd31};
        vecs[3] = '{7'h12, 7'h14, 2'b00, 1'b0, 5'd0,  5'd31, 5'd0};
        vecs[4] = '{7'h12, 7'h14, 2'b01, 1'b1, 5'd31, 5'd0,  5'd0};
        vecs[5] = '{7'h00, 7'h20, 2'b11, 1'b0, 5'd0,  5'd31, 5'd0};
        vecs[6] = '{7'h12, 7'h10, 2'b11, 1'b1, 5'd31, 5'd0,  5'd0};

        rst = 1'b1; pxl_cen = 1'b0; cpu_cen = 1'b0; pal_cs = 1'b0; cpu_rnw = 1'b1;
        cpu_addr = '0; cpu_dout = 8'd0; LHBL = 1'b1; LVBL = 1'b1;
        layer_pxl = '0; gfx_en = '0; prio_rev = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset red", red, 0);
        chk("reset green", green, 0);
        chk("reset blue", blue, 0);
        chk("reset LHBL_dly", LHBL_dly, 0);
        chk("reset LVBL_dly", LVBL_dly, 0);
        chk("reset pal_dout", pal_dout, 0);
        rst = 1'b0;
        restart_model();

        for (int a = 0; a < 256; a++) cpu_wr(a, 8'(a));
        for (int a = 256; a < 512; a++) cpu_wr(a, 8'($urandom));
        for (int a = 0; a < 512; a++) cpu_rd("readback", a);

        pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_cen = 1'b0; cpu_addr = 9'd5; cpu_dout = 8'hAA;
        @(posedge clk); #1;
        cpu_rd("no write without cpu_cen", 5);

        cpu_wr(9'h000, 8'hE0); cpu_wr(9'h001, 8'h03);
        cpu_wr(9'h024, 8'h1F); cpu_wr(9'h025, 8'h00);
        cpu_wr(9'h128, 8'h00); cpu_wr(9'h129, 8'h7C);

        foreach (vecs[i]) begin
            drive(vecs[i].l0, vecs[i].l1, vecs[i].en, vecs[i].rev);
            repeat (3) px_tick("vec model");
            chk($sformatf("vec%0d red", i), red, vecs[i].r);
            chk($sformatf("vec%0d green", i), green, vecs[i].g);
            chk($sformatf("vec%0d blue", i), blue, vecs[i].b);
        end

        drive(7'h12, 7'h14, 2'b11, 1'b0);
        for (int i = 0; i < 16; i++) begin
            LHBL = !(i >= 4 && i < 8);
            px_tick("blank model");
            chk($sformatf("blank%0d LHBL_dly", i), LHBL_dly, !(i >= 6 && i < 10));
            chk($sformatf("blank%0d red", i), red, (i >= 6 && i < 10) ? 0 : 31);
        end
        LHBL = 1'b1;

        drive(7'h12, 7'h14, 2'b01, 1'b0);
        repeat (4) px_tick("coll fill");
        pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_cen = 1'b1; cpu_addr = 9'h024; cpu_dout = 8'h0A;
        pal[9'h024] = 8'h0A;
        px_tick("coll write");
        pal_cs = 1'b0; cpu_rnw = 1'b1; cpu_cen = 1'b0;
        px_tick("coll old");
        chk("coll old red", red, 31);
        px_tick("coll new");
        chk("coll new red", red, 10);
        repeat (2) idle_tick("hold");

        rst = 1'b1;
        @(posedge clk); #1;
        chk("midreset red", red, 0);
        chk("midreset green", green, 0);
        chk("midreset blue", blue, 0);
        chk("midreset LHBL_dly", LHBL_dly, 0);
        chk("midreset LVBL_dly", LVBL_dly, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        restart_model();
        cpu_rd("after reset rd 024", 9'h024);
        cpu_rd("after reset rd 129", 9'h129);
        cpu_rd("after reset rd 0ff", 9'h0FF);
        repeat (4) px_tick("after reset");

        for (int i = 0; i < 600; i++) begin
            layer_pxl = (LAYERS*PXLW)'($urandom);
            gfx_en = LAYERS'($urandom);
            prio_rev = 1'($urandom);
            LHBL = ($urandom % 8) != 0;
            LVBL = ($urandom % 8) != 0;
            pal_cs = 1'b1; cpu_rnw = 1'b1;
            cpu_addr = PALW'($urandom);
            if ($urandom % 3 != 0) px_tick("rnd");
            else idle_tick("rnd hold");
            chk("rnd rd", pal_dout, pal[cpu_addr]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
